// File: rtl/simon_iter_core.sv
// rtl/simon_iter_core.sv - iterative SIMON 2N/MN core with internal round-key store; option macro SIMON_DECRYPT_EN
module simon_iter_core #(
    parameter int N  = 64,
    parameter int M  = 4,
    parameter int T  = 72,
    parameter int ZS = 4,
    parameter int Co = 7
) (
    input  logic             clk,
    input  logic             nR,
    input  logic             newKey,
    input  logic [M*N-1:0]   key,
    output logic             ldKey,
    output logic             doneKey,
    input  logic             newData,
    input  logic             enc_dec,
    input  logic [2*N-1:0]   plain,
    output logic             ldData,
    output logic             doneData,
    input  logic             readData,
    output logic [2*N-1:0]   cipher
);

    typedef enum logic [2:0] {
        NOKEY,
        KEXP,
        READY,
        RUN,
        DONE
    } state_t;

    // z sequences written in reading order: the leftmost digit is z[0]
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
    localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
    localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;
    localparam logic [61:0] ZSEQ = (ZS == 0) ? Z0 :
                                   (ZS == 1) ? Z1 :
                                   (ZS == 2) ? Z2 :
                                   (ZS == 3) ? Z3 : Z4;

    localparam logic [Co-1:0] CNT_LAST = Co'(T - 1);
    localparam logic [Co-1:0] CNT_KEY0 = Co'(M);

    function automatic logic [N-1:0] rol(input logic [N-1:0] a, input int s);
        return (a << s) | (a >> (N - s));
    endfunction

    function automatic logic [N-1:0] ror(input logic [N-1:0] a, input int s);
        return (a >> s) | (a << (N - s));
    endfunction

    function automatic logic [N-1:0] round_f(input logic [N-1:0] a);
        return (rol(a, 1) & rol(a, 8)) ^ rol(a, 2);
    endfunction

    state_t          state_q, state_d;
    logic [Co-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    x_q, x_d;
    logic [N-1:0]    y_q, y_d;
    logic [2*N-1:0]  cipher_q, cipher_d;
    logic [N-1:0]    rk_q [0:T-1];

    logic            accept_key;
    logic [N-1:0]    ks_tmp;
    logic [N-1:0]    k_new;
    int unsigned     z_off;
    logic [5:0]      z_idx;
    logic [N-1:0]    rk_cur;
    logic [N-1:0]    round_x;
    logic [N-1:0]    round_y;
    logic            last_round;
    logic [Co-1:0]   cnt_step;

    // Status outputs are pure decodes of the state register
    assign ldKey    = (state_q == NOKEY) || (state_q == READY);
    assign ldData   = (state_q == READY);
    assign doneKey  = (state_q == READY) || (state_q == RUN) || (state_q == DONE);
    assign doneData = (state_q == DONE);
    assign cipher   = cipher_q;

    // A data request in READY wins over a simultaneous key request
    assign accept_key = nR && newKey &&
                        ((state_q == NOKEY) || ((state_q == READY) && !newData));

    // Next expanded round key k(cnt) from the words already in the store
    always_comb begin
        ks_tmp = ror(rk_q[cnt_q - Co'(1)], 3);
        if (M == 4) begin
            ks_tmp = ks_tmp ^ rk_q[cnt_q - Co'(3)];
        end
        z_off = (32'(cnt_q) - 32'(M)) % 62;
        z_idx = 6'(61 - z_off);
        k_new = ~rk_q[cnt_q - CNT_KEY0] ^ ks_tmp ^ ror(ks_tmp, 1)
                ^ N'(ZSEQ[z_idx]) ^ N'(3);
    end

    // Round-key store: host words on key accept, one expanded word per KEXP cycle
    always_ff @(posedge clk) begin
        if (accept_key) begin
            for (int j = 0; j < M; j++) begin
                rk_q[j] <= key[j*N +: N];
            end
        end else if (state_q == KEXP) begin
            rk_q[cnt_q] <= k_new;
        end
    end

    assign rk_cur = rk_q[cnt_q];

`ifdef SIMON_DECRYPT_EN
    logic mode_q, mode_d;

    // Direction of the block in flight, latched on data accept
    always_ff @(posedge clk) begin
        if (!nR) begin
            mode_q <= 1'b1;
        end else begin
            mode_q <= mode_d;
        end
    end

    // One round in the latched direction; decrypt walks the keys downwards
    always_comb begin
        mode_d = mode_q;
        if ((state_q == READY) && newData) begin
            mode_d = enc_dec;
        end
        if (mode_q) begin
            round_x    = y_q ^ round_f(x_q) ^ rk_cur;
            round_y    = x_q;
            last_round = (cnt_q == CNT_LAST);
            cnt_step   = cnt_q + Co'(1);
        end else begin
            round_x    = y_q;
            round_y    = x_q ^ round_f(y_q) ^ rk_cur;
            last_round = (cnt_q == '0);
            cnt_step   = cnt_q - Co'(1);
        end
    end
`else
    logic unused_enc_dec;
    assign unused_enc_dec = enc_dec;

    // One encryption round; the direction input has no effect in this build
    always_comb begin
        round_x    = y_q ^ round_f(x_q) ^ rk_cur;
        round_y    = x_q;
        last_round = (cnt_q == CNT_LAST);
        cnt_step   = cnt_q + Co'(1);
    end
`endif

    // Next-state, counter and data-path control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        cipher_d = cipher_q;
        case (state_q)
            NOKEY: begin
                if (newKey) begin
                    cnt_d   = CNT_KEY0;
                    state_d = KEXP;
                end
            end
            KEXP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = READY;
                end else begin
                    cnt_d = cnt_q + Co'(1);
                end
            end
            READY: begin
                if (newData) begin
                    x_d     = plain[2*N-1:N];
                    y_d     = plain[N-1:0];
`ifdef SIMON_DECRYPT_EN
                    cnt_d   = enc_dec ? '0 : CNT_LAST;
`else
                    cnt_d   = '0;
`endif
                    state_d = RUN;
                end else if (newKey) begin
                    cnt_d   = CNT_KEY0;
                    state_d = KEXP;
                end
            end
            RUN: begin
                x_d = round_x;
                y_d = round_y;
                if (last_round) begin
                    cipher_d = {round_x, round_y};
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_step;
                end
            end
            DONE: begin
                if (readData) begin
                    state_d = READY;
                end
            end
            default: begin
                state_d = NOKEY;
            end
        endcase
    end

    // State and data registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!nR) begin
            state_q  <= NOKEY;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            cipher_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            cipher_q <= cipher_d;
        end
    end

endmodule
